// File: rtl/tail_light_seq.sv
// Turn-signal sequencer: progressive left/right sweep over N_LAMPS lamps per side plus hazard flash.
// Optional feature macro: TAIL_BRAKE_EN (brake override of the non-sweeping side).
module tail_light_seq #(
    parameter int N_LAMPS = 3,
    parameter int DIV     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    input  logic               brake,
    output logic [N_LAMPS-1:0] lamp_l,
    output logic [N_LAMPS-1:0] lamp_r,
    output logic               busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(N_LAMPS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(N_LAMPS);

    typedef enum logic [2:0] {
        S_IDLE, S_LEFT, S_RIGHT, S_HAZ_ON, S_HAZ_OFF
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick;
    logic              hz;
    logic [N_LAMPS-1:0] lamp_l_q, lamp_l_d, lamp_r_q, lamp_r_d;

    function automatic logic [N_LAMPS-1:0] therm(input logic [SW-1:0] k);
        logic [N_LAMPS-1:0] t;
        for (int i = 0; i < N_LAMPS; i++) t[i] = (i < int'(k));
        return t;
    endfunction

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign hz    = hazard | (left & right);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            step_q   <= '0;
            lamp_l_q <= '0;
            lamp_r_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            step_q   <= step_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
        end
    end

    // Next state only moves on tick; a started sweep runs to completion unless hazard pre-empts.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hz) begin
                        state_d = S_HAZ_ON;
                        step_d  = '0;
                    end else if (left) begin
                        state_d = S_LEFT;
                        step_d  = SW'(1);
                    end else if (right) begin
                        state_d = S_RIGHT;
                        step_d  = SW'(1);
                    end
                end
                S_LEFT, S_RIGHT: begin
                    if (hz) begin
                        state_d = S_HAZ_ON;
                        step_d  = '0;
                    end else if (step_q < STEP_MAX) begin
                        step_d  = step_q + SW'(1);
                    end else begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end
                end
                S_HAZ_ON: state_d = S_HAZ_OFF;
                S_HAZ_OFF: state_d = hz ? S_HAZ_ON : S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Lamp registers load the decode of the next state so they track the state register.
    always_comb begin
        lamp_l_d = '0;
        lamp_r_d = '0;
        case (state_d)
            S_LEFT:   lamp_l_d = therm(step_d);
            S_RIGHT:  lamp_r_d = therm(step_d);
            S_HAZ_ON: begin
                lamp_l_d = '1;
                lamp_r_d = '1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

`ifdef TAIL_BRAKE_EN
    logic brake_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) brake_q <= 1'b0;
        else        brake_q <= brake;
    end

    always_comb begin
        lamp_l = lamp_l_q;
        lamp_r = lamp_r_q;
        if (brake_q) begin
            case (state_q)
                S_IDLE: begin
                    lamp_l = '1;
                    lamp_r = '1;
                end
                S_LEFT:  lamp_r = '1;
                S_RIGHT: lamp_l = '1;
                default: ;
            endcase
        end
    end
`else
    logic unused_brake;
    assign unused_brake = brake;
    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;
`endif

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: two configurations (3 lamps/DIV 1, 5 lamps/DIV 4) share stimulus, checked against a behavioural model.
module tb_tail_light_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
    logic [2:0] l3, r3;
    logic [4:0] l5, r5;
    logic       b3, b5;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tail_light_seq #(.N_LAMPS(3), .DIV(1)) u3 (
        .clk(clk), .reset(rst), .left(left), .right(right), .hazard(hazard), .brake(brake),
        .lamp_l(l3), .lamp_r(r3), .busy(b3));

    tail_light_seq #(.N_LAMPS(5), .DIV(4)) u5 (
        .clk(clk), .reset(rst), .left(left), .right(right), .hazard(hazard), .brake(brake),
        .lamp_l(l5), .lamp_r(r5), .busy(b5));

    // Model: mode 0 idle, 1 sweeping left, 2 sweeping right, 3 flash on, 4 flash off
    localparam int IDL = 0, LFT = 1, RGT = 2, HON = 3, HOFF = 4;
    int NV[2] = '{3, 5};
    int DV[2] = '{1, 4};
    int m_cnt[2], m_mode[2], m_k[2], m_brk[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_cnt[id] = 0; m_mode[id] = IDL; m_k[id] = 0; m_brk[id] = 0;
        end
    endtask

    task automatic model_tick(input bit il, ir, ih, ib);
        for (int id = 0; id < 2; id++) begin
            bit tk, hz;
            tk = (m_cnt[id] == DV[id] - 1);
            hz = ih | (il & ir);
            m_cnt[id] = tk ? 0 : m_cnt[id] + 1;
            m_brk[id] = ib;
            if (tk) begin
                if (m_mode[id] == HON) m_mode[id] = HOFF;
                else if (hz) begin m_mode[id] = HON; m_k[id] = 0; end
                else if (m_mode[id] == IDL) begin
                    if (il)      begin m_mode[id] = LFT; m_k[id] = 1; end
                    else if (ir) begin m_mode[id] = RGT; m_k[id] = 1; end
                end else if (m_mode[id] == HOFF) m_mode[id] = IDL;
                else if (m_k[id] < NV[id]) m_k[id]++;
                else begin m_mode[id] = IDL; m_k[id] = 0; end
            end
        end
    endtask

    function automatic int exp_side(input int id, input bit is_left);
        int all, v;
        all = (1 << NV[id]) - 1;
        v = 0;
        if (m_mode[id] == HON) v = all;
        else if (m_mode[id] == LFT && is_left) v = (1 << m_k[id]) - 1;
        else if (m_mode[id] == RGT && !is_left) v = (1 << m_k[id]) - 1;
`ifdef TAIL_BRAKE_EN
        if (m_brk[id] != 0 && (m_mode[id] == IDL || (m_mode[id] == LFT && !is_left) ||
                               (m_mode[id] == RGT && is_left)))
            v = all;
`endif
        return v;
    endfunction

    task automatic check_all();
        chk("u3.lamp_l", 32'(l3), exp_side(0, 1));
        chk("u3.lamp_r", 32'(r3), exp_side(0, 0));
        chk("u3.busy",   32'(b3), (m_mode[0] != IDL) ? 1 : 0);
        chk("u5.lamp_l", 32'(l5), exp_side(1, 1));
        chk("u5.lamp_r", 32'(r5), exp_side(1, 0));
        chk("u5.busy",   32'(b5), (m_mode[1] != IDL) ? 1 : 0);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic step(input bit irst, il, ir, ih, ib);
        rst = irst; left = il; right = ir; hazard = ih; brake = ib;
        if (!irst) model_reset();
        @(posedge clk);
        if (irst) model_tick(il, ir, ih, ib);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int seq1[8] = '{1, 3, 7, 0, 1, 3, 7, 0};
        int seq3[4] = '{7, 0, 7, 0};
        model_reset();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_all();
        end

        // Held left: two full sweeps with all-off gap
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 0);
            chk("plan_left_seq", 32'(l3), seq1[i]);
            chk("plan_left_r0", 32'(r3), 0);
        end
        step(1, 0, 0, 0, 0);
        while (m_mode[1] != IDL) step(1, 0, 0, 0, 0);

        // One-cycle right pulse completes the sweep
        step(1, 0, 1, 0, 0);
        chk("plan_right_1", 32'(r3), 1);
        step(1, 0, 0, 0, 0); chk("plan_right_2", 32'(r3), 3);
        step(1, 0, 0, 0, 0); chk("plan_right_3", 32'(r3), 7);
        step(1, 0, 0, 0, 0); chk("plan_right_4", 32'(r3), 0); chk("plan_right_busy", 32'(b3), 0);
        repeat (24) step(1, 0, 0, 0, 0);

        // left & right together flashes
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 0, 0);
            chk("plan_lr_l", 32'(l3), seq3[i]);
            chk("plan_lr_r", 32'(r3), seq3[i]);
        end
        step(1, 0, 0, 0, 0);
        chk("plan_lr_idle", 32'(b3), 0);
        repeat (8) step(1, 0, 0, 0, 0);

        // Slow config: left sweep then hazard pre-empts mid-sweep
        repeat (6) step(1, 1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 1, 0);
        repeat (12) step(1, 0, 0, 0, 0);

        // Asynchronous reset mid LEFT(2)
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("plan_arst_pre", 32'(l3), 3);
        #2 rst = 1'b0;
        #1 chk("plan_arst_l3", 32'(l3), 0);
        chk("plan_arst_l5", 32'(l5), 0);
        chk("plan_arst_busy", 32'(b3), 0);
        model_reset();
        @(negedge clk);
        check_all();
        step(1, 1, 0, 0, 0);
        chk("plan_arst_after", 32'(l3), 1);
        repeat (4) step(1, 0, 0, 0, 0);

        // Brake during left sweep, then hazard
        repeat (4) step(1, 1, 0, 0, 1);
        repeat (4) step(1, 0, 0, 1, 1);
        repeat (10) step(1, 0, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bit rr, il, ir, ih, ib;
            rr = ($urandom_range(0, 99) >= 2);
            il = ($urandom_range(0, 99) < 35);
            ir = ($urandom_range(0, 99) < 35);
            ih = ($urandom_range(0, 99) < 8);
            ib = ($urandom_range(0, 99) < 40);
            step(rr, il, ir, ih, ib);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised turn-signal sequencer, successor to the fixed three-lamp-per-side tail-light FSM. Drives `N_LAMPS` lamps per side with a left/right progressive sweep and a hazard flash mode. The sequence rate is set by an internal prescaler. It sits between the driver-input debouncers and the lamp drivers in the lighting subsystem.

## Interface
- `N_LAMPS`, default 3: lamps per side, must be ≥ 2; bit 0 is the innermost lamp (L1/R1).
- `DIV`, default 1: clock cycles per sequencer step, must be ≥ 1; 1 means every cycle.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low. 0 forces reset state immediately; release is synchronised by the next `clk` edge.
- `left`  in  1: left turn request, level.
- `right`  in  1: right turn request, level.
- `hazard`  in  1: hazard request, level.
- `brake`  in  1: brake request, level. Used only with `TAIL_BRAKE_EN`.
- `lamp_l`  out  N_LAMPS: left lamps, 1 = lit.
- `lamp_r`  out  N_LAMPS: right lamps, 1 = lit.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- Prescaler:
  - Free-running counter, width max(1, $clog2(DIV)), counts 0..DIV-1 and wraps.
  - `tick` is high on the cycle where the count equals DIV-1. With DIV=1, `tick` is always high.
- States: IDLE, LEFT(k), RIGHT(k), HAZ_ON, HAZ_OFF. k runs 1..N_LAMPS. The state register holds type plus a step count of width $clog2(N_LAMPS+1).
- State and step change only on clock edges where `tick`=1. Inputs on non-tick cycles are ignored.
- Hazard condition: `hz = hazard | (left & right)`.
- Transitions, evaluated on tick:
  - IDLE: if `hz` → HAZ_ON; else if `left` → LEFT(1); else if `right` → RIGHT(1); else stay in IDLE.
  - LEFT(k), k < N_LAMPS: if `hz` → HAZ_ON (pre-empts); else → LEFT(k+1). The `left` input is not rechecked, so a started sweep completes.
  - LEFT(N_LAMPS): if `hz` → HAZ_ON; else → IDLE.
  - RIGHT(k): symmetric to LEFT(k).
  - HAZ_ON → HAZ_OFF, unconditionally.
  - HAZ_OFF: if `hz` → HAZ_ON; else → IDLE. Hazard therefore always exits through an all-off step.
- Outputs, registered and decoded from state:
  - LEFT(k): `lamp_l` has the low k bits set (thermometer); `lamp_r` = 0.
  - RIGHT(k): `lamp_r` has the low k bits set; `lamp_l` = 0.
  - HAZ_ON: both sides all ones.
  - IDLE and HAZ_OFF: both sides all zero.
- A full sweep lasts N_LAMPS steps, then one IDLE step. A held `left` therefore repeats with an all-off gap of at least one step.

## Timing
- Reset values: state IDLE, prescaler 0, `lamp_l`=0, `lamp_r`=0, `busy`=0.
- Latency with DIV=1: a request sampled at edge n shows on the lamps after edge n, i.e. one cycle.
- Latency with DIV>1: up to DIV cycles, depending on prescaler phase.
- Lamp outputs change only on tick edges or on reset assertion.
- Reset asserted mid-sweep or mid-hazard: all lamps drop to 0 asynchronously and the prescaler restarts at 0.
- Simultaneous `left` and `right` is treated as hazard, never as a sweep.
- If `hazard` and `left` are both asserted in IDLE, hazard wins.

## Configuration
- `TAIL_BRAKE_EN` defined:
  - Whenever `brake`=1 and the state is IDLE, LEFT or RIGHT, the idle side's lamps are forced to all ones. In IDLE, both sides are forced to all ones.
  - The sweeping side keeps its thermometer pattern.
  - In HAZ_ON and HAZ_OFF, `brake` is ignored.
  - The override is combinational on registered state plus a registered copy of `brake`, so brake latency is one cycle, independent of DIV.
- `TAIL_BRAKE_EN` undefined: the `brake` port remains and is ignored. Lamp outputs are exactly the state decode.

## Test plan
- N_LAMPS=3, DIV=1: reset=0 for 4 cycles, then reset=1 with `left`=1 held for 8 cycles → `lamp_l` = 001, 011, 111, 000, 001, 011, 111, 000; `lamp_r`=000 throughout.
- N_LAMPS=3, DIV=1: pulse `right`=1 for one cycle → `lamp_r` = 001, 011, 111, 000 with `right` low after the first step; `busy` is high for exactly 3 cycles.
- N_LAMPS=3, DIV=1: `left`=`right`=1 for 4 cycles, then both 0 → both sides 111, 000, 111, 000, then IDLE.
- N_LAMPS=5, DIV=4: `left`=1 from IDLE → each thermometer step holds exactly 4 cycles (00001, then 00011 … 11111); assert `hazard` during step 2 → next tick gives both sides 11111.
- N_LAMPS=3, DIV=1: assert reset=0 asynchronously mid-cycle during LEFT(2) → `lamp_l`=000 before the next edge; after release, first request behaves as from IDLE.
- With `TAIL_BRAKE_EN`: `brake`=1 during a left sweep → `lamp_r`=111 while `lamp_l` sweeps. Then `hazard`=1 → brake is ignored and both sides flash 111/000.
